// File: rtl/adc_reader.sv
// SPI read-out of one ADC conversion per trigger rising edge, delivered as
// AXI4-Stream beats; every PACKET_LEN-th beat carries tlast and pulses last.
module adc_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int SCK_DIV    = 2,
  parameter int PACKET_LEN = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        trigger,
  output logic        last,
  output logic        spi_sck,
  input  logic        spi_sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overrun
);
  localparam int DIV_W  = $clog2(SCK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int BEAT_W = $clog2(PACKET_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic                  trig_prev;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [DATA_WIDTH-1:0] sr;

  logic start, phase_end, done, hs, load;
  logic [BEAT_W-1:0] beat_nxt;

  always_comb begin
    start     = trigger & ~trig_prev;
    phase_end = (state == SHIFT) && (div_cnt == DIV_W'(SCK_DIV - 1));
    done      = phase_end && spi_sck && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    hs        = m_axis_tvalid & m_axis_tready;
    // Beat index of the next sample to load, accounting for a handshake this cycle.
    beat_nxt  = beat_cnt;
    if (hs) beat_nxt = m_axis_tlast ? '0 : beat_cnt + BEAT_W'(1);
    load      = done && (!m_axis_tvalid || m_axis_tready);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      trig_prev     <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      beat_cnt      <= '0;
      sr            <= '0;
      spi_sck       <= 1'b0;
      last          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      trig_prev <= trigger;
      beat_cnt  <= beat_nxt;
      last      <= hs & m_axis_tlast;

      case (state)
        IDLE: begin
          spi_sck <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
          end
        end
        SHIFT: begin
          if (start) overrun <= 1'b1;
          if (phase_end) begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              // Capture on the same edge that raises spi_sck.
              sr <= DATA_WIDTH'({sr, spi_sdo});
            end else if (done) begin
              state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        if (load) begin
          m_axis_tdata  <= 32'(sr);
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= (beat_nxt == BEAT_W'(PACKET_LEN - 1));
        end else begin
          overrun <= 1'b1;
        end
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader: single read, held/re-trigger, reset abort,
// packet boundary and backpressure with a behavioural ADC serial model.
module tb_adc_reader;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic        last, spi_sck, spi_sdo;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, overrun;
  logic        m_axis_tready = 1'b1;

  int checks = 0;
  int failures = 0;

  adc_reader #(.DATA_WIDTH(24), .SCK_DIV(2), .PACKET_LEN(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .trigger(trigger), .last(last),
    .spi_sck(spi_sck), .spi_sdo(spi_sdo), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  // ADC model: presents word MSB first, advancing after each falling spi_sck.
  logic [23:0] word = '0;
  int          idx = 0;
  assign spi_sdo = (idx < 24) ? word[23 - idx] : 1'b0;
  always @(negedge spi_sck) idx++;

  int          sck_edges = 0;
  always @(posedge spi_sck) sck_edges++;

  // Stream monitor, sampled mid-cycle.
  int          beats = 0, last_pulses = 0, last_err = 0;
  logic [63:0] tl_hist = '0;
  logic [31:0] last_data = '0;
  logic        prev_tl_hs = 1'b0;
  always @(negedge aclk) begin
    if (last !== prev_tl_hs) last_err++;
    if (last === 1'b1) last_pulses++;
    prev_tl_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      tl_hist[beats] = m_axis_tlast;
      last_data = m_axis_tdata;
      beats++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_read(input logic [23:0] w);
    word = w;
    idx = 0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  initial begin
    int e0, b0, lp0, n;
    logic [31:0] held;
    logic [8:0]  mask;

    // Reset state
    tick(3);
    check("rst_sck", 32'(spi_sck), 0);
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", 32'(m_axis_tlast), 0);
    check("rst_last", 32'(last), 0);
    check("rst_overrun", 32'(overrun), 0);
    aresetn = 1'b1;
    tick(2);

    // Single read: latency, edge count, data
    e0 = sck_edges; b0 = beats;
    word = 24'hA5C3F1; idx = 0;
    trigger = 1'b1;
    n = 0;
    while (m_axis_tvalid !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (n == 1) trigger = 1'b0;
    end
    check("single_latency", n, 97);
    check("single_tdata", m_axis_tdata, 32'h00A5C3F1);
    check("single_tlast", 32'(m_axis_tlast), 0);
    tick(5);
    check("single_edges", sck_edges - e0, 24);
    check("single_beats", beats - b0, 1);
    check("single_tvalid_clr", 32'(m_axis_tvalid), 0);
    check("single_overrun", 32'(overrun), 0);

    // Held trigger: one read only
    e0 = sck_edges; b0 = beats;
    word = 24'h3C5A96; idx = 0;
    trigger = 1'b1;
    tick(500);
    trigger = 1'b0;
    tick(5);
    check("held_edges", sck_edges - e0, 24);
    check("held_beats", beats - b0, 1);
    check("held_data", last_data, 32'h003C5A96);
    check("held_overrun", 32'(overrun), 0);

    // Re-trigger during shift
    e0 = sck_edges; b0 = beats;
    start_read(24'h0F1E2D);
    tick(39);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(200);
    check("retrig_edges", sck_edges - e0, 24);
    check("retrig_beats", beats - b0, 1);
    check("retrig_data", last_data, 32'h000F1E2D);
    check("retrig_overrun", 32'(overrun), 1);

    // Reset mid-shift aborts immediately
    start_read(24'h777777);
    tick(50);
    check("midrst_sck_hi", 32'(spi_sck), 1);
    aresetn = 1'b0;
    #1;
    check("midrst_sck", 32'(spi_sck), 0);
    check("midrst_tvalid", 32'(m_axis_tvalid), 0);
    check("midrst_overrun", 32'(overrun), 0);
    tick(3);
    aresetn = 1'b1;
    tick(2);

    // Packet boundary: 9 beats, tlast on 4 and 8, beat count restarted
    b0 = beats; lp0 = last_pulses;
    for (int i = 0; i < 9; i++) begin
      start_read(24'h100000 + 24'(i));
      tick(199);
    end
    check("pkt_beats", beats - b0, 9);
    for (int i = 0; i < 9; i++) mask[i] = tl_hist[b0 + i];
    check("pkt_tlast_mask", 32'(mask), 32'h88);
    check("pkt_last_pulses", last_pulses - lp0, 2);
    check("pkt_last_timing", last_err, 0);
    check("pkt_last_data", last_data, 32'h00100008);

    // Backpressure: second sample dropped, first held stable
    b0 = beats;
    m_axis_tready = 1'b0;
    start_read(24'h123456);
    tick(99);
    check("bp_tvalid", 32'(m_axis_tvalid), 1);
    held = m_axis_tdata;
    check("bp_held_data", held, 32'h00123456);
    tick(20);
    start_read(24'h654321);
    tick(180);
    check("bp_stable", m_axis_tdata, held);
    check("bp_overrun", 32'(overrun), 1);
    check("bp_no_beats", beats - b0, 0);
    m_axis_tready = 1'b1;
    tick(10);
    check("bp_beats", beats - b0, 1);
    check("bp_data", last_data, 32'h00123456);
    check("bp_tvalid_clr", 32'(m_axis_tvalid), 0);
    check("bp_last_timing", last_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_reader.md
Name: adc_reader

Overview:
- Serial read-out engine on the far side of the ADC trigger/last interface.
- Each rising edge of `trigger` (ADC conversion done, busy released) starts one SPI-style read of the ADC result: the block drives `spi_sck` and shifts in `spi_sdo` MSB first.
- Each result is emitted as one AXI4-Stream beat toward the DMA.
- After `PACKET_LEN` beats the block marks `tlast` and pulses `last` back to the trigger block, which stops or re-arms the conversion sequence.

Parameters:
- `DATA_WIDTH`, 24: bits shifted per conversion (1..32).
- `SCK_DIV`, 2: `spi_sck` half-period in aclk cycles (>=1).
- `PACKET_LEN`, 1024: beats per DMA packet (>=1); the `PACKET_LEN`-th beat carries `tlast`.

Ports:
- `aclk`  in  1  sole clock; all logic on its rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `trigger`  in  1  conversion-ready strobe, synchronous to aclk; rising edge starts a read.
- `last`  out  1  one-cycle pulse when the `tlast` beat is accepted.
- `spi_sck`  out  1  serial clock to ADC; idles low.
- `spi_sdo`  in  1  serial data from ADC, valid at `spi_sck` rising edge.
- `m_axis_tdata`  out  32  sample, zero-extended in bits [DATA_WIDTH-1:0].
- `m_axis_tvalid`  out  1  AXI4-Stream valid.
- `m_axis_tready`  in  1  AXI4-Stream ready.
- `m_axis_tlast`  out  1  final beat of packet.
- `overrun`  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - `last`, `spi_sck`, `m_axis_tvalid`, `m_axis_tlast`, `overrun` = 0; `m_axis_tdata` = 0.
  - State = IDLE; bit, divider and beat counters = 0; trigger history register = 0.
  - Reset mid-shift or mid-handshake aborts immediately; the partial sample and any pending beat are discarded.
- Edge detect: `trig_prev` is registered every cycle; start = `trigger & ~trig_prev`.
- IDLE:
  - start -> SHIFT; clear bit counter, divider counter and shift register.
  - `spi_sck` stays 0.
- SHIFT:
  - `spi_sck` low for `SCK_DIV` cycles, then high for `SCK_DIV` cycles, repeated `DATA_WIDTH` times.
  - `spi_sdo` is captured into the shift register (MSB first) on the same aclk edge that drives `spi_sck` 0->1.
  - At the end of the `DATA_WIDTH`-th high phase: `spi_sck` -> 0, state -> IDLE, and a completed sample is produced.
  - Read time is 2*SCK_DIV*DATA_WIDTH cycles from SHIFT entry to sample completion.
- Sample hand-off, single-entry output register:
  - If `m_axis_tvalid`=0, or `m_axis_tvalid & m_axis_tready` in the same cycle: load `tdata`, set `tvalid`=1, set `tlast` = (beat counter == PACKET_LEN-1).
  - Otherwise (previous beat still stalled) the new sample is dropped, `overrun` is set, and the beat counter is not advanced.
- AXI4-Stream rules:
  - `tdata` and `tlast` are stable while `tvalid` & !`tready`.
  - `tvalid` clears on handshake unless it is reloaded in the same cycle.
- Beat counter:
  - Increments on each accepted handshake.
  - On handshake with `tlast`=1 it wraps to 0 and `last`=1 for exactly the following cycle.
- A start while in SHIFT is ignored and sets `overrun`.
- `overrun` is sticky until reset.
- Simultaneous start in the cycle SHIFT completes: the start is an overrun (the block is still SHIFT in that cycle).
- `trigger` held high generates only one read.
- Latency from the `trigger` rising edge (cycle 0) to `tvalid`=1 is 1 + 2*SCK_DIV*DATA_WIDTH cycles; the default is 97.
- Implementation size: roughly 150-250 lines; no combinational path from `m_axis_tready` to any output except through registers.

Test Plan:
- Single read: `SCK_DIV`=2, `DATA_WIDTH`=24, `spi_sdo` model drives 0xA5C3F1, `tready`=1; one `trigger` pulse -> exactly 24 `spi_sck` rising edges, `tvalid` high 97 cycles after the edge, `tdata`=0x00A5C3F1, `tlast`=0, `overrun`=0.
- Packet boundary: `PACKET_LEN`=4, 9 triggers spaced 200 cycles apart -> `tlast`=1 on beats 4 and 8 only, `last` pulses one cycle after each of those handshakes, beat 9 has `tlast`=0.
- Backpressure: `tready`=0 for 300 cycles across two triggers 120 cycles apart -> first beat held with stable `tdata`, second sample dropped, `overrun`=1; releasing `tready` delivers only the first beat.
- Re-trigger during shift: second `trigger` edge 40 cycles after the first -> still 24 `spi_sck` edges, single beat, `overrun`=1.
- Held trigger: `trigger` high for 500 cycles -> exactly one read and one beat, `overrun`=0.
- Reset mid-operation: `aresetn` low at cycle 50 of SHIFT -> `spi_sck`=0 and `tvalid`=0 immediately; after release, next trigger gives a correct sample with beat count restarted (`tlast` on the 4th beat with `PACKET_LEN`=4).
